turbo_frame_serializer: RTL
===========================

TURBO_FRAME_SERIALIZER -- requirements
Module: turbo_frame_serializer

Interface
REQ-001 Parameter SYNC, default 8'hB8: frame sync header, sent MSB first.
REQ-002 Parameter CNT_W, default 8: width of frame_cnt.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 sys_byte  input  8  systematic data byte.
REQ-008 par_byte  input  8  encoder output byte: [7:4] = parity1 nibble, [3:0] = parity2 nibble.
REQ-009 out_valid  output  1  ser_bit valid.
REQ-010 out_ready  input  1  downstream accepts ser_bit.
REQ-011 ser_bit  output  1  serial output bit.
REQ-012 frame_start  output  1  high with the first header bit.
REQ-013 frame_end  output  1  high with the last payload bit.
REQ-014 frame_cnt  output  CNT_W  count of completed frames.

Function
REQ-015 The block SHALL accept {sys_byte, par_byte} on any rising edge where in_valid and in_ready are both high.
REQ-016 Accepted words SHALL go into a 2-entry FIFO; in_ready = (FIFO count < 2), from registered count only. A pop on the same edge SHALL NOT raise in_ready when full.
REQ-017 The FSM SHALL have states IDLE, HDR, PAY.
REQ-018 IDLE with FIFO non-empty: pop the head word into a shift/hold register, go to HDR on the same edge; no same-cycle bypass from input to output.
REQ-019 Latency: word accepted into an empty FIFO at edge N, block in IDLE -> out_valid high starting after edge N+1.
REQ-020 HDR SHALL present SYNC[7] down to SYNC[0], one bit per out_valid&out_ready handshake; then go to PAY.
REQ-021 PAY SHALL present 16 bits: for i = 0..7, sys[i], then parity bit.
REQ-022 Parity bit for even i is parity1[i/2]; for odd i it is parity2[(i-1)/2].
REQ-023 out_valid SHALL be high in HDR and PAY and low in IDLE.
REQ-024 ser_bit, frame_start and frame_end SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 A 5-bit bit counter SHALL advance only on a handshake.
REQ-026 The frame is 24 bits: 8 header bits, then 16 payload bits.
REQ-027 frame_start = 1 only for header bit 0; frame_end = 1 only for payload bit 15.
REQ-028 On the frame_end handshake, frame_cnt SHALL increment, wrapping from 2^CNT_W-1 to 0.
REQ-029 On that handshake, if the FIFO is non-empty, the FSM SHALL pop and go to HDR with no idle cycle; otherwise it SHALL go to IDLE.
REQ-030 Push and pop on the same edge SHALL leave the FIFO count unchanged and keep word order.
REQ-031 in_valid while in_ready=0 SHALL be ignored; no word is lost or corrupted.
REQ-032 sys_byte/par_byte changes after acceptance SHALL NOT affect a frame in flight.

Reset
REQ-033 rst high SHALL immediately force: FSM IDLE, FIFO empty, bit counter 0, frame_cnt 0.
REQ-034 While rst is high, outputs SHALL be: out_valid 0, ser_bit 0, frame_start 0, frame_end 0, in_ready 0.
REQ-035 in_ready SHALL be 1 from the first rising edge after rst deasserts.
REQ-036 Reset mid-frame SHALL discard the partial frame and all queued words; no partial frame resumes.

Verification
REQ-037 Single frame: sys=8'hA5, par=8'h3C, out_ready=1 -> 24 bits 1011_1000_1100_1100_0011_0011, frame_start on bit 0, frame_end on bit 23, frame_cnt 0->1.
REQ-038 Backpressure: same word, out_ready toggles 1/0 each cycle -> identical 24-bit sequence, outputs stable while stalled, frame spans 48 cycles.
REQ-039 Back-to-back: three words pushed as fast as in_ready allows -> 72 contiguous valid bits, no gap between frames, in_ready low while FIFO holds 2 words, frame_cnt = 3.
REQ-040 Wrap: CNT_W=2, five frames -> frame_cnt sequence 1,2,3,0,1.
REQ-041 Reset mid-frame: assert rst at payload bit 5 with 1 word queued -> out_valid 0 immediately, frame_cnt 0; a new word then yields a full fresh 24-bit frame.
REQ-042 Full-FIFO push: in_valid held high with FIFO full for 10 cycles -> no acceptance until a pop, then exactly one word accepted on the following edge.

Source files
------------

// File: rtl/turbo_frame_serializer_if.sv
// Handshake bundle for the turbo frame serializer: word input side,
// serial bit output side and the completed-frame counter.
interface turbo_frame_serializer_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       sys_byte;
    logic [7:0]       par_byte;
    logic             out_valid;
    logic             out_ready;
    logic             ser_bit;
    logic             frame_start;
    logic             frame_end;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output in_valid, sys_byte, par_byte, out_ready,
        input  in_ready, out_valid, ser_bit, frame_start, frame_end, frame_cnt
    );

    modport slave (
        input  in_valid, sys_byte, par_byte, out_ready,
        output in_ready, out_valid, ser_bit, frame_start, frame_end, frame_cnt
    );
endinterface

// File: rtl/turbo_frame_serializer.sv
// Serializes {systematic, parity} words into 24-bit frames: 8 sync bits, then
// 16 payload bits interleaving each systematic bit with one parity bit.
//
// state | meaning
// IDLE  | no frame in flight, out_valid low, waiting for a queued word
// HDR   | presenting sync header bits 0..7
// PAY   | presenting payload bits 8..23
module turbo_frame_serializer #(
    parameter logic [7:0] SYNC  = 8'hB8,
    parameter int         CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    turbo_frame_serializer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t           state;
    logic [15:0]      mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             run;
    logic [23:0]      shreg;
    logic [4:0]       bit_cnt;
    logic             valid_q;
    logic             start_q;
    logic             end_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;
    logic             hs;
    logic             last_bit;
    logic [23:0]      next_frame;

    // Whole frame is precomputed at pop time so later input changes cannot leak in.
    function automatic logic [23:0] build_frame(input logic [15:0] w);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            p[15 - 2*i] = w[8 + i];
            p[14 - 2*i] = (i % 2 == 0) ? w[4 + i/2] : w[(i - 1)/2];
        end
        return {SYNC, p};
    endfunction

    // run holds in_ready low during reset and releases it on the first edge after.
    assign bus.in_ready    = run & (count != 2'd2);
    assign push            = bus.in_valid & bus.in_ready;
    assign hs              = valid_q & bus.out_ready;
    assign last_bit        = (bit_cnt == 5'd23);
    assign pop             = (count != 2'd0) & ((state == IDLE) | (hs & last_bit));
    assign next_frame      = build_frame(mem[rd_ptr]);

    assign bus.out_valid   = valid_q;
    assign bus.ser_bit     = shreg[23];
    assign bus.frame_start = start_q;
    assign bus.frame_end   = end_q;
    assign bus.frame_cnt   = cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.sys_byte, bus.par_byte};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run    <= 1'b0;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            run <= 1'b1;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= 5'd0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (hs && last_bit) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (pop) begin
                state   <= HDR;
                shreg   <= next_frame;
                bit_cnt <= 5'd0;
                valid_q <= 1'b1;
                start_q <= 1'b1;
                end_q   <= 1'b0;
            end else if (hs) begin
                if (last_bit) begin
                    state   <= IDLE;
                    shreg   <= '0;
                    bit_cnt <= 5'd0;
                    valid_q <= 1'b0;
                    start_q <= 1'b0;
                    end_q   <= 1'b0;
                end else begin
                    shreg   <= {shreg[22:0], 1'b0};
                    bit_cnt <= bit_cnt + 5'd1;
                    start_q <= 1'b0;
                    end_q   <= (bit_cnt == 5'd22);
                    if (bit_cnt == 5'd7) begin
                        state <= PAY;
                    end
                end
            end
        end
    end
endmodule
